// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, state/byte types and the SubBytes FSM encoding
package aes_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_BYTES  = 16;

    typedef logic [DATA_WIDTH*NUM_BYTES-1:0] aes_state_t;
    typedef logic [DATA_WIDTH-1:0]           aes_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } sub_state_e;

endpackage

// File: rtl/aes_s_table.sv
// aes_s_table: combinational AES forward S-box indexed by the byte's high/low nibbles
module aes_s_table
    import aes_pkg::*;
(
    input  logic [3:0] row_num,
    input  logic [3:0] col_num,
    output aes_byte_t  aes_table_out
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign aes_table_out = SBOX[{row_num, col_num}];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: SubBytes over a 128-bit state, one byte per cycle through a single S-box
module aes_sub_bytes_seq
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);

    sub_state_e fsm, fsm_n;
    aes_state_t state_q, state_n;
    logic [3:0] idx, idx_n;
    aes_byte_t  cur_byte, sub_byte;

    assign cur_byte = state_q[127-8*idx -: 8];

    aes_s_table u_s_table (
        .row_num       (cur_byte[7:4]),
        .col_num       (cur_byte[3:0]),
        .aes_table_out (sub_byte)
    );

    assign in_ready  = fsm == IDLE;
    assign out_valid = fsm == DONE;
    assign busy      = fsm != IDLE;
    assign out_state = state_q;

    // state register; reset discards any partially substituted state
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            state_q <= '0;
            idx     <= '0;
        end else begin
            fsm     <= fsm_n;
            state_q <= state_n;
            idx     <= idx_n;
        end
    end

    // next state: load on accept, substitute byte idx in place while in SUB, hold in DONE
    always_comb begin
        fsm_n   = fsm;
        state_n = state_q;
        idx_n   = idx;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    state_n = in_state;
                    idx_n   = '0;
                    fsm_n   = SUB;
                end
            end
            SUB: begin
                state_n[127-8*idx -: 8] = sub_byte;
                idx_n = idx + 4'd1;
                fsm_n = (idx == 4'd15) ? DONE : SUB;
            end
            DONE:    fsm_n = out_ready ? IDLE : DONE;
            default: fsm_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb_aes_sub_bytes_seq: scoreboard bench for the sequential SubBytes stage
module tb_aes_sub_bytes_seq;

    logic         clk = 0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic [127:0] sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] V_ZERO = 128'h0;
    localparam logic [127:0] E_ZERO = 128'h63636363_63636363_63636363_63636363;
    localparam logic [127:0] V_DIAG = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] E_DIAG = 128'h638293C3_1BFC33F5_C4EEACEA_4BC12816;
    localparam logic [127:0] V_53   = 128'h53535353_53535353_53535353_53535353;
    localparam logic [127:0] E_53   = 128'hEDEDEDED_EDEDEDED_EDEDEDED_EDEDEDED;

    aes_sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        if (sb_q.size() == 0) check({tag, "_empty"}, 1'b1, 1'b0);
        else check(tag, out_state, sb_q.pop_front());
    endtask

    task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] exp, input int stall);
        logic [127:0] held;
        int n = 0;
        check({tag, "_ready"}, in_ready, 1'b1);
        in_valid = 1;
        in_state = din;
        sb_q.push_back(exp);
        tick();
        in_valid = 0;
        in_state = ~din;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 16);
        pop_check({tag, "_out"});
        held = out_state;
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_state"}, out_state, held);
            check({tag, "_stall_inrdy"}, in_ready, 1'b0);
            check({tag, "_stall_valid"}, out_valid, 1'b1);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        check({tag, "_done_valid"}, out_valid, 1'b0);
        check({tag, "_done_inrdy"}, in_ready, 1'b1);
    endtask

    initial begin
        int acc[2];
        int k;
        int outs;
        logic seen_valid;
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        in_state = '0;
        tick();
        tick();
        rst = 0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_state", out_state, 128'h0);

        run_one("zero", V_ZERO, E_ZERO, 0);
        run_one("diag", V_DIAG, E_DIAG, 0);
        run_one("stall", V_DIAG, E_DIAG, 10);

        in_valid = 1;
        in_state = V_53;
        tick();
        in_valid = 0;
        check("mid_busy", busy, 1'b1);
        seen_valid = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen_valid |= out_valid;
        end
        rst = 1;
        tick();
        rst = 0;
        check("mid_in_ready", in_ready, 1'b1);
        check("mid_busy_clr", busy, 1'b0);
        check("mid_out_state", out_state, 128'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_valid |= out_valid;
        end
        check("mid_no_valid", seen_valid, 1'b0);
        run_one("after_rst", V_53, E_53, 0);

        out_ready = 1;
        in_valid = 1;
        k = 0;
        outs = 0;
        acc[0] = 0;
        acc[1] = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                pop_check("b2b_out");
                outs++;
            end
            if (in_ready && k < 2) begin
                in_state = (k == 0) ? V_DIAG : V_ZERO;
                sb_q.push_back((k == 0) ? E_DIAG : E_ZERO);
                acc[k] = c;
                k++;
                in_valid = 1;
            end else begin
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_valid = !(in_ready && k >= 2);
            end
            tick();
        end
        in_valid = 0;
        out_ready = 0;
        check("b2b_accepts", k, 2);
        check("b2b_outputs", outs, 2);
        check("b2b_spacing", acc[1] - acc[0], 18);
        check("b2b_queue_left", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
